// File: rtl/uart_rx.sv
// Purpose: 8-bit UART receiver with a 2-flop input synchronizer. Define UART_RX_PARITY_EN for an even-parity bit (8E1); the default build is 8N1.
// Latency: rx_data/rx_valid update one cycle after the stop-bit sample, about 2 sync cycles plus 9.5 bit times (10.5 with parity) after the start edge.
// Backpressure: none on the line; a byte that completes while rx_valid is still unacknowledged is dropped and overrun pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

  logic          rxd_meta, rxd_sync;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          accept, ferr;
`ifdef UART_RX_PARITY_EN
  logic          par_bit, par_bit_nxt;
  logic          perr;
`endif

  // Reset to the idle level so releasing reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_bit_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CW'(1);
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    accept      = 1'b0;
    ferr        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_nxt = par_bit;
    perr        = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rxd_sync) begin
          state_nxt   = START;
          bit_idx_nxt = '0;
        end
      end
      START: begin
        // Mid-start-bit recheck rejects short glitches silently.
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          state_nxt = rxd_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          shift_nxt   = {rxd_sync, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          par_bit_nxt = rxd_sync;
          state_nxt   = STOP;
        end
      end
`endif
      STOP: begin
        // A low stop bit outranks a parity mismatch.
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (!rxd_sync) begin
            ferr      = 1'b1;
            state_nxt = WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
          end else if ((^shift) != par_bit) begin
            perr      = 1'b1;
            state_nxt = IDLE;
`endif
          end else begin
            accept    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_nxt = '0;
        if (rxd_sync) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= 1'b0;
      if (accept) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_err <= 1'b0;
    else      parity_err <= perr;
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit; honours UART_RX_PARITY_EN.
module tb_uart_rx;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif
  // Start edge to result: 2 sync + 1 detect + half bit + remaining bit periods through stop.
  localparam int LAT = 3 + CPB / 2 + (PARITY_ON ? 10 : 9) * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun, busy;

  int errors = 0, checks = 0;
  int cyc = 0, t0 = 0, rise_cyc = -1;
  int n_ferr = 0, n_perr = 0, n_ovr = 0, n_vld_low = 0;
  logic vld_prev = 1'b0, watch_low = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_err)  n_ferr++;
    if (parity_err) n_perr++;
    if (overrun)    n_ovr++;
    if (rx_valid && !vld_prev) rise_cyc = cyc;
    if (watch_low && !rx_valid) n_vld_low++;
    vld_prev = rx_valid;
  end

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    @(posedge clk); #1;
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PARITY_ON) drive_bit((^b) ^ par_flip);
    drive_bit(stop_bit);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    @(posedge clk); #1 rx_ack = 1'b1;
    @(posedge clk); #1 rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", rx_valid); end
    checks++; if ({frame_err, parity_err, overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %0b expected 000", {frame_err, parity_err, overrun}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    @(posedge clk); #1 rst = 1'b1;
    idle(5);
  endtask

  task automatic test_basic();
    int f0, p0;
    f0 = n_ferr; p0 = n_perr;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(2);
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %0h expected a5", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b expected 1", rx_valid); end
    checks++; if (rise_cyc - t0 !== LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", rise_cyc - t0, LAT); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %0b expected 0", busy); end
    checks++; if (n_ferr - f0 + n_perr - p0 !== 0) begin errors++; $display("FAIL basic_errs: got %0d expected 0", n_ferr - f0 + n_perr - p0); end
    ack_pulse();
    #2;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_ack_clear: got %0b expected 0", rx_valid); end
  endtask

  task automatic test_glitch();
    int f0, p0, o0;
    f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
    @(posedge clk); #1 rxd = 1'b0;
    repeat (8) @(posedge clk);
    #1 rxd = 1'b1;
    idle(40);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %0b expected 0", rx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %0b expected 0", busy); end
    checks++; if ((n_ferr - f0) + (n_perr - p0) + (n_ovr - o0) !== 0) begin errors++; $display("FAIL glitch_flags: got %0d expected 0", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0)); end
  endtask

  task automatic test_break();
    int f0, p0;
    f0 = n_ferr; p0 = n_perr;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    idle(20);
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL break_ferr_count: got %0d expected 1", n_ferr - f0); end
    checks++; if (n_perr - p0 !== 0) begin errors++; $display("FAIL break_perr_count: got %0d expected 0", n_perr - p0); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL break_valid: got %0b expected 0", rx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_busy: got %0b expected 0", busy); end
    send_frame(8'h55, 1'b1, 1'b0);
    idle(2);
    checks++; if (rx_data !== 8'h55 || rx_valid !== 1'b1) begin errors++; $display("FAIL break_recover: got %0h/%0b expected 55/1", rx_data, rx_valid); end
    ack_pulse();
  endtask

  task automatic test_overrun();
    int o0;
    o0 = n_ovr;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(2);
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data: got %0h expected 11", rx_data); end
    checks++; if (n_ovr - o0 !== 1) begin errors++; $display("FAIL ovr_count: got %0d expected 1", n_ovr - o0); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %0b expected 1", rx_valid); end
    o0 = n_ovr;
    n_vld_low = 0;
    watch_low = 1'b1;
    fork
      send_frame(8'h22, 1'b1, 1'b0);
      begin
        @(posedge clk); #1;
        repeat (LAT - 1) @(posedge clk);
        #1 rx_ack = 1'b1;
        @(posedge clk); #1 rx_ack = 1'b0;
      end
    join
    idle(2);
    watch_low = 1'b0;
    checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL ackcomp_data: got %0h expected 22", rx_data); end
    checks++; if (n_ovr - o0 !== 0) begin errors++; $display("FAIL ackcomp_ovr: got %0d expected 0", n_ovr - o0); end
    checks++; if (n_vld_low !== 0) begin errors++; $display("FAIL ackcomp_valid_gap: got %0d low cycles expected 0", n_vld_low); end
    ack_pulse();
  endtask

  task automatic test_reset_midframe();
    int f0, p0, o0;
    @(posedge clk); #1;
    drive_bit(1'b0);
    rxd = 1'b1;
    repeat (4 * CPB + CPB / 2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_state: got busy=%0b valid=%0b expected 0/0", busy, rx_valid); end
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
    idle(4 * CPB);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_no_restart: got %0b expected 0", busy); end
    send_frame(8'h81, 1'b1, 1'b0);
    idle(2);
    checks++; if (rx_data !== 8'h81 || rx_valid !== 1'b1) begin errors++; $display("FAIL midrst_data: got %0h/%0b expected 81/1", rx_data, rx_valid); end
    checks++; if ((n_ferr - f0) + (n_perr - p0) + (n_ovr - o0) !== 0) begin errors++; $display("FAIL midrst_flags: got %0d expected 0", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0)); end
    ack_pulse();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int p0;
    p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(2);
    checks++; if (rx_data !== 8'h07 || rx_valid !== 1'b1) begin errors++; $display("FAIL par_good: got %0h/%0b expected 07/1", rx_data, rx_valid); end
    ack_pulse();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2);
    checks++; if (n_perr - p0 !== 1) begin errors++; $display("FAIL par_bad_count: got %0d expected 1", n_perr - p0); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL par_bad_valid: got %0b expected 0", rx_valid); end
  endtask
`endif

  // Reference model: frame outcome decided from the bits sent and whether a byte is pending.
  task automatic test_random();
    logic [7:0] b, exp_data;
    logic       stop_bit, pflip, exp_valid;
    int         ef, ep, eo, f0, p0, o0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    idle(4);
    exp_data = 8'h00; exp_valid = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse();
        exp_valid = 1'b0;
      end
      b = 8'($urandom);
      stop_bit = ($urandom_range(0, 5) != 0);
      pflip = ($urandom_range(0, 4) == 0);
      ef = 0; ep = 0; eo = 0;
      if (!stop_bit) ef = 1;
      else if (PARITY_ON && pflip) ep = 1;
      else if (exp_valid) eo = 1;
      else begin exp_valid = 1'b1; exp_data = b; end
      f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
      send_frame(b, stop_bit, pflip);
      idle(6);
      checks++; if (rx_valid !== exp_valid) begin errors++; $display("FAIL rnd%0d_valid: got %0b expected %0b", n, rx_valid, exp_valid); end
      checks++; if (rx_data !== exp_data) begin errors++; $display("FAIL rnd%0d_data: got %0h expected %0h", n, rx_data, exp_data); end
      checks++; if (n_ferr - f0 !== ef) begin errors++; $display("FAIL rnd%0d_ferr: got %0d expected %0d", n, n_ferr - f0, ef); end
      checks++; if (n_perr - p0 !== ep) begin errors++; $display("FAIL rnd%0d_perr: got %0d expected %0d", n, n_perr - p0, ep); end
      checks++; if (n_ovr - o0 !== eo) begin errors++; $display("FAIL rnd%0d_ovr: got %0d expected %0d", n, n_ovr - o0, eo); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10417, meaning clk cycles per bit (100 MHz / 9600 baud); legal range 4..65535.
REQ-002 Port clk  input  1  single system clock; all state on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-low.
REQ-004 Port rxd  input  1  serial line from the thermostat TX pin, idle high, asynchronous to clk.
REQ-005 Port rx_ack  input  1  consumer acknowledge; clears rx_valid.
REQ-006 Port rx_data  output  8  last accepted byte.
REQ-007 Port rx_valid  output  1  rx_data holds an unacknowledged byte.
REQ-008 Port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 Port parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 when parity disabled).
REQ-010 Port overrun  output  1  one-cycle pulse: completed byte dropped because rx_valid was still set.
REQ-011 Port busy  output  1  high in every state except IDLE.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value (2-cycle latency).
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-014 IDLE: synchronized rxd low -> START, bit counter cleared.
REQ-015 START: after CLKS_PER_BIT/2 cycles (integer division), sample; low -> DATA, high -> IDLE (glitch rejected, no flag).
REQ-016 DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, shifted into an internal register; after bit 7 -> PARITY if enabled, else STOP.
REQ-017 STOP: sample after CLKS_PER_BIT cycles; high and no parity error -> byte accepted, -> IDLE; low -> frame_err, byte discarded, -> WAIT_HIGH.
REQ-018 WAIT_HIGH SHALL remain until synchronized rxd is high, then -> IDLE (a held-low break line yields exactly one frame_err).
REQ-019 Acceptance: rx_data and rx_valid SHALL update on the cycle after the stop sample.
REQ-020 rx_valid SHALL stay high until a cycle with rx_ack high, then clear on the next edge; rx_ack with rx_valid low has no effect.
REQ-021 Completion with rx_valid high and rx_ack low: new byte dropped, rx_data unchanged, overrun pulses one cycle.
REQ-022 Completion in the same cycle as rx_ack: new byte loaded, rx_valid stays high, no overrun.
REQ-023 Bit-period counter width SHALL be clog2(CLKS_PER_BIT); counter never wraps mid-bit.
REQ-024 Only one of frame_err/parity_err SHALL pulse per frame; frame_err takes priority.

Reset
REQ-025 rst low SHALL asynchronously force IDLE, synchronizer flops to 1, counters to 0, rx_data to 8'h00, rx_valid/frame_err/parity_err/overrun/busy to 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no flag; after release, reception restarts only on a new falling edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: PARITY state present, one even-parity bit after bit 7; mismatch -> parity_err pulse with the stop sample, byte discarded, -> IDLE (or WAIT_HIGH if stop also low).
REQ-028 Macro UART_RX_PARITY_EN undefined: frame is 8N1, PARITY state absent, parity_err tied 0.

Verification (bench CLKS_PER_BIT=16)
REQ-029 Send 8'hA5 8N1 -> rx_data=8'hA5, rx_valid high 1 cycle after stop sample, busy low afterward.
REQ-030 8-cycle low glitch on idle rxd -> FSM returns to IDLE, no rx_valid, no error flags.
REQ-031 Send 8'h3C with stop bit low, line then held low 100 cycles -> exactly one frame_err pulse, rx_valid stays 0, then 8'h55 received correctly after line high.
REQ-032 Send 8'h11 then 8'h22 without rx_ack -> rx_data=8'h11, one overrun pulse; repeat with rx_ack on completion cycle -> rx_data=8'h22, no overrun.
REQ-033 rst low at DATA bit 4 of 8'hFF, released 20 cycles later, then send 8'h81 -> rx_data=8'h81, no error flags.
REQ-034 With UART_RX_PARITY_EN: 8'h07 with parity 1 -> accepted; with parity 0 -> parity_err pulse, rx_valid stays 0.
